// File: rtl/apb4_mst_pkg.sv
// Shared types and constants for the APB4 master bridge.
package apb4_mst_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_mst_tmo.sv
// Saturating ACCESS-phase timeout counter; o_tc flags the last allowed wait cycle.
module apb4_mst_tmo #(
  parameter int TIMEOUT = 16,
  parameter int CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clear,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_enable,
  output logic          o_tc
);

  localparam logic [CW-1:0] TC_VAL  = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] SAT_VAL = {CW{1'b1}};

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                          r_cnt <= '0;
    else if (i_clear)                      r_cnt <= '0;
    else if (i_load)                       r_cnt <= i_load_val;
    else if (i_enable && r_cnt != SAT_VAL) r_cnt <= r_cnt + 1'b1;
  end

  // TIMEOUT of zero never terminates, so the bridge waits forever.
  assign o_tc = (TIMEOUT != 0) && (r_cnt == TC_VAL);

endmodule

// File: rtl/dffer.sv
// Common register primitive: async active-low reset with load enable.
module dffer #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  o_q <= RST_VAL;
    else if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/apb4_master_bridge.sv
// APB4 initiator: single requests from a valid/ready channel become SETUP/ACCESS transfers,
// with the result returned on a held valid/ready response channel.
module apb4_master_bridge
  import apb4_mst_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  input  logic [2:0]              req_prot_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic                    pwrite_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam int REQ_WIDTH  = 1 + ADDR_WIDTH + DATA_WIDTH + STRB_WIDTH + 3;
  localparam logic [REQ_WIDTH-1:0] REQ_RST = {{(REQ_WIDTH - 3){1'b0}}, PPROT_DEFAULT};

  state_e                r_state;
  state_e                w_next;
  logic                  w_accept;
  logic                  w_done;
  logic                  w_tmo_tc;
  logic [REQ_WIDTH-1:0]  w_req_d;
  logic [REQ_WIDTH-1:0]  w_req_q;
  logic [DATA_WIDTH:0]   w_rsp_d;
  logic [DATA_WIDTH:0]   w_rsp_q;

  assign w_accept = (r_state == IDLE) && req_valid_i;
  assign w_done   = (r_state == ACCESS) && (pready_i || w_tmo_tc);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (req_valid_i) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (pready_i || w_tmo_tc) w_next = RESP;
      RESP:    if (rsp_ready_i) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Handshake and APB control decode only the state register, never the live inputs.
  always_comb begin
    req_ready_o = 1'b0;
    psel_o      = 1'b0;
    penable_o   = 1'b0;
    rsp_valid_o = 1'b0;
    unique case (r_state)
      IDLE:    req_ready_o = 1'b1;
      SETUP:   psel_o      = 1'b1;
      ACCESS:  begin
        psel_o    = 1'b1;
        penable_o = 1'b1;
      end
      RESP:    rsp_valid_o = 1'b1;
      default: req_ready_o = 1'b0;
    endcase
  end

  // Reads never drive byte strobes onto the bus.
  assign w_req_d = {req_write_i, req_addr_i, req_wdata_i,
                    req_write_i ? req_strb_i : {STRB_WIDTH{1'b0}}, req_prot_i};

  dffer #(.WIDTH(REQ_WIDTH), .RST_VAL(REQ_RST)) u_req_reg (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_en    (w_accept),
    .i_d     (w_req_d),
    .o_q     (w_req_q)
  );

  assign {pwrite_o, paddr_o, pwdata_o, pstrb_o, pprot_o} = w_req_q;

  // A completing slave wins over the timeout; aborts and writes return zero data.
  assign w_rsp_d = pready_i ?
                   {pslverr_i, (pwrite_o || pslverr_i) ? {DATA_WIDTH{1'b0}} : prdata_i} :
                   {1'b1, {DATA_WIDTH{1'b0}}};

  dffer #(.WIDTH(DATA_WIDTH + 1), .RST_VAL('0)) u_rsp_reg (
    .i_clk   (clk_i),
    .i_rst_n (rst_n_i),
    .i_en    (w_done),
    .i_d     (w_rsp_d),
    .o_q     (w_rsp_q)
  );

  assign {rsp_err_o, rsp_rdata_o} = w_rsp_q;

  apb4_mst_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .i_clk      (clk_i),
    .i_rst_n    (rst_n_i),
    .i_clear    (w_accept),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_enable   ((r_state == ACCESS) && !pready_i),
    .o_tc       (w_tmo_tc)
  );

endmodule
